// File: rtl/router_ingress_ctrl.sv
// rtl/router_ingress_ctrl.sv - 1x3 router ingress sequencer: header decode, FIFO steering, parity check, timeouts
module router_ingress_ctrl #(
    parameter int TIMEOUT = 30,
    parameter int CNT_W   = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pkt_valid,
    input  logic [7:0] data_in,
    input  logic [2:0] fifo_full,
    input  logic [2:0] fifo_empty,
    input  logic [2:0] read_enb,
    output logic       busy,
    output logic [2:0] we_enb,
    output logic [7:0] fifo_din,
    output logic       lfd_state,
    output logic [2:0] vld_out,
    output logic [2:0] soft_reset,
    output logic       err
);

    typedef enum logic [2:0] {
        DECODE, WAIT_EMPTY, LOAD_FIRST, LOAD_DATA, FIFO_FULL, CHECK_PARITY, DROP
    } state_t;

    state_t           state, state_nxt;
    logic [7:0]       hdr, par, rx_par;
    logic [1:0]       dest;
    logic [CNT_W-1:0] cnt [3];

    logic       latch_hdr, par_acc, cap_rx, clr_par, do_check;
    logic [2:0] we_nxt, dest_oh;
    logic [7:0] din_nxt;
    logic       full_dest, empty_dest, sr_dest;
    logic [3:0] full4, empty4, sr4;

    assign vld_out = ~fifo_empty;

    // Address 3 has no FIFO; padding to 4 bits keeps every dest lookup in range.
    assign full4      = {1'b0, fifo_full};
    assign empty4     = {1'b0, fifo_empty};
    assign sr4        = {1'b0, soft_reset};
    assign full_dest  = full4[dest];
    assign empty_dest = empty4[dest];
    assign sr_dest    = sr4[dest];
    assign dest_oh    = (dest == 2'd0) ? 3'b001 :
                        (dest == 2'd1) ? 3'b010 :
                        (dest == 2'd2) ? 3'b100 : 3'b000;

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        lfd_state = 1'b0;
        we_nxt    = 3'b000;
        din_nxt   = 8'h00;
        latch_hdr = 1'b0;
        par_acc   = 1'b0;
        cap_rx    = 1'b0;
        clr_par   = 1'b0;
        do_check  = 1'b0;
        case (state)
            DECODE: begin
                if (pkt_valid) begin
                    latch_hdr = 1'b1;
                    if (data_in[1:0] == 2'd3)      state_nxt = DROP;
                    else if (empty4[data_in[1:0]]) state_nxt = LOAD_FIRST;
                    else                           state_nxt = WAIT_EMPTY;
                end
            end
            WAIT_EMPTY: begin
                busy = 1'b1;
                if (sr_dest) begin
                    clr_par   = 1'b1;
                    state_nxt = DROP;
                end else if (empty_dest) begin
                    state_nxt = LOAD_FIRST;
                end
            end
            LOAD_FIRST: begin
                busy      = 1'b1;
                lfd_state = 1'b1;
                if (sr_dest) begin
                    clr_par   = 1'b1;
                    state_nxt = DROP;
                end else begin
                    we_nxt    = dest_oh;
                    din_nxt   = hdr;
                    state_nxt = LOAD_DATA;
                end
            end
            LOAD_DATA: begin
                busy = full_dest;
                if (sr_dest) begin
                    clr_par   = 1'b1;
                    state_nxt = DROP;
                end else if (full_dest) begin
                    state_nxt = FIFO_FULL;
                end else begin
                    we_nxt  = dest_oh;
                    din_nxt = data_in;
                    if (pkt_valid) begin
                        par_acc = 1'b1;
                    end else begin
                        cap_rx    = 1'b1;
                        state_nxt = CHECK_PARITY;
                    end
                end
            end
            FIFO_FULL: begin
                busy = 1'b1;
                if (sr_dest) begin
                    clr_par   = 1'b1;
                    state_nxt = DROP;
                end else if (!full_dest) begin
                    state_nxt = LOAD_DATA;
                end
            end
            CHECK_PARITY: begin
                busy = 1'b1;
                if (sr_dest) begin
                    clr_par   = 1'b1;
                    state_nxt = DROP;
                end else begin
                    do_check  = 1'b1;
                    state_nxt = DECODE;
                end
            end
            DROP: begin
                if (!pkt_valid) state_nxt = DECODE;
            end
            default: state_nxt = DECODE;
        endcase
        if (rst) begin
            busy      = 1'b0;
            lfd_state = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= DECODE;
            hdr      <= 8'h00;
            par      <= 8'h00;
            rx_par   <= 8'h00;
            dest     <= 2'd0;
            err      <= 1'b0;
            we_enb   <= 3'b000;
            fifo_din <= 8'h00;
        end else begin
            state    <= state_nxt;
            we_enb   <= we_nxt;
            fifo_din <= din_nxt;
            if (latch_hdr) begin
                hdr  <= data_in;
                dest <= data_in[1:0];
                err  <= 1'b0;
            end
            if (latch_hdr)    par <= data_in;
            else if (clr_par) par <= 8'h00;
            else if (par_acc) par <= par ^ data_in;
            if (cap_rx)   rx_par <= data_in;
            if (do_check) err    <= (par != rx_par);
        end
    end

    // A destination holding unread data for TIMEOUT straight cycles gets a one-cycle soft reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                cnt[i]        <= '0;
                soft_reset[i] <= 1'b0;
            end else if (vld_out[i] && !read_enb[i]) begin
                if (cnt[i] == CNT_W'(TIMEOUT - 1)) begin
                    cnt[i]        <= '0;
                    soft_reset[i] <= 1'b1;
                end else begin
                    cnt[i]        <= cnt[i] + CNT_W'(1);
                    soft_reset[i] <= 1'b0;
                end
            end else begin
                cnt[i]        <= '0;
                soft_reset[i] <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_router_ingress_ctrl.sv
// tb/tb_router_ingress_ctrl.sv - vector-table bench for router_ingress_ctrl
module tb_router_ingress_ctrl;

    logic       clk;
    logic       rst;
    logic       pkt_valid;
    logic [7:0] data_in;
    logic [2:0] fifo_full, fifo_empty, read_enb;
    logic       busy, lfd_state, err;
    logic [2:0] we_enb, vld_out, soft_reset;
    logic [7:0] fifo_din;

    int n_cmp = 0;
    int n_bad = 0;

    router_ingress_ctrl #(.TIMEOUT(30), .CNT_W(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .pkt_valid  (pkt_valid),
        .data_in    (data_in),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty),
        .read_enb   (read_enb),
        .busy       (busy),
        .we_enb     (we_enb),
        .fifo_din   (fifo_din),
        .lfd_state  (lfd_state),
        .vld_out    (vld_out),
        .soft_reset (soft_reset),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One record = inputs held for one cycle; busy/lfd checked before the edge,
    // registered outputs checked just after it.
    typedef struct packed {
        logic       rst;
        logic       pv;
        logic [7:0] din;
        logic [2:0] full;
        logic [2:0] empty;
        logic [2:0] rd;
        logic       busy;
        logic       lfd;
        logic [2:0] we;
        logic [7:0] fdin;
        logic       err;
        logic [2:0] sr;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic r, logic pv, logic [7:0] din, logic [2:0] full,
                                logic [2:0] empty, logic [2:0] rd, logic b, logic l,
                                logic [2:0] we, logic [7:0] fdin, logic e, logic [2:0] sr);
        vec_t v;
        v.rst = r; v.pv = pv; v.din = din; v.full = full; v.empty = empty; v.rd = rd;
        v.busy = b; v.lfd = l; v.we = we; v.fdin = fdin; v.err = e; v.sr = sr;
        return v;
    endfunction

    task automatic chk(string name, int idx, logic [7:0] act, logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s vec %0d: got %h want %h", name, idx, act, exp);
        end
    endtask

    task automatic apply(vec_t v, int idx);
        rst = v.rst; pkt_valid = v.pv; data_in = v.din;
        fifo_full = v.full; fifo_empty = v.empty; read_enb = v.rd;
        #1;
        chk("busy", idx, {7'd0, busy}, {7'd0, v.busy});
        chk("lfd_state", idx, {7'd0, lfd_state}, {7'd0, v.lfd});
        chk("vld_out", idx, {5'd0, vld_out}, {5'd0, ~v.empty});
        @(posedge clk);
        #1;
        chk("we_enb", idx, {5'd0, we_enb}, {5'd0, v.we});
        if (v.we != 3'b000 || v.rst) chk("fifo_din", idx, fifo_din, v.fdin);
        chk("err", idx, {7'd0, err}, {7'd0, v.err});
        chk("soft_reset", idx, {5'd0, soft_reset}, {5'd0, v.sr});
    endtask

    task automatic add(logic r, logic pv, logic [7:0] din, logic [2:0] full, logic [2:0] empty,
                       logic b, logic l, logic [2:0] we, logic [7:0] fdin, logic e);
        vecs.push_back(mk(r, pv, din, full, empty, 3'b000, b, l, we, fdin, e, 3'b000));
    endtask

    localparam logic [2:0] E = 3'b111;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; pkt_valid = 1'b0; data_in = 8'h00;
        fifo_full = 3'b000; fifo_empty = E; read_enb = 3'b000;

        add(1, 0, 8'h00, 0, E, 0, 0, 3'b000, 8'h00, 0);
        add(1, 0, 8'h00, 0, E, 0, 0, 3'b000, 8'h00, 0);
        // good packet to FIFO1
        add(0, 1, 8'h0D, 0, E, 0, 0, 3'b000, 8'h00, 0);
        add(0, 1, 8'h11, 0, E, 1, 1, 3'b010, 8'h0D, 0);
        add(0, 1, 8'h11, 0, E, 0, 0, 3'b010, 8'h11, 0);
        add(0, 1, 8'h22, 0, E, 0, 0, 3'b010, 8'h22, 0);
        add(0, 1, 8'h33, 0, E, 0, 0, 3'b010, 8'h33, 0);
        add(0, 0, 8'h0D, 0, E, 0, 0, 3'b010, 8'h0D, 0);
        add(0, 0, 8'h00, 0, E, 1, 0, 3'b000, 8'h00, 0);
        add(0, 0, 8'h00, 0, E, 0, 0, 3'b000, 8'h00, 0);
        // bad parity: err sticks until the next header
        add(0, 1, 8'h0D, 0, E, 0, 0, 3'b000, 8'h00, 0);
        add(0, 1, 8'h11, 0, E, 1, 1, 3'b010, 8'h0D, 0);
        add(0, 1, 8'h11, 0, E, 0, 0, 3'b010, 8'h11, 0);
        add(0, 1, 8'h22, 0, E, 0, 0, 3'b010, 8'h22, 0);
        add(0, 1, 8'h33, 0, E, 0, 0, 3'b010, 8'h33, 0);
        add(0, 0, 8'h00, 0, E, 0, 0, 3'b010, 8'h00, 0);
        add(0, 0, 8'h00, 0, E, 1, 0, 3'b000, 8'h00, 1);
        add(0, 0, 8'h00, 0, E, 0, 0, 3'b000, 8'h00, 1);
        add(0, 0, 8'h00, 0, E, 0, 0, 3'b000, 8'h00, 1);
        // FIFO1 full stall after payload 11
        add(0, 1, 8'h0D, 3'b000, E, 0, 0, 3'b000, 8'h00, 0);
        add(0, 1, 8'h11, 3'b000, E, 1, 1, 3'b010, 8'h0D, 0);
        add(0, 1, 8'h11, 3'b000, E, 0, 0, 3'b010, 8'h11, 0);
        add(0, 1, 8'h22, 3'b010, E, 1, 0, 3'b000, 8'h00, 0);
        add(0, 1, 8'h22, 3'b010, E, 1, 0, 3'b000, 8'h00, 0);
        add(0, 1, 8'h22, 3'b010, E, 1, 0, 3'b000, 8'h00, 0);
        add(0, 1, 8'h22, 3'b000, E, 1, 0, 3'b000, 8'h00, 0);
        add(0, 1, 8'h22, 3'b000, E, 0, 0, 3'b010, 8'h22, 0);
        add(0, 1, 8'h33, 3'b000, E, 0, 0, 3'b010, 8'h33, 0);
        add(0, 0, 8'h0D, 3'b000, E, 0, 0, 3'b010, 8'h0D, 0);
        add(0, 0, 8'h00, 3'b000, E, 1, 0, 3'b000, 8'h00, 0);
        // FIFO2 not empty at header: wait, then load
        add(0, 1, 8'h0E, 0, 3'b011, 0, 0, 3'b000, 8'h00, 0);
        add(0, 1, 8'h11, 0, 3'b011, 1, 0, 3'b000, 8'h00, 0);
        add(0, 1, 8'h11, 0, E,      1, 0, 3'b000, 8'h00, 0);
        add(0, 1, 8'h11, 0, E,      1, 1, 3'b100, 8'h0E, 0);
        add(0, 1, 8'h11, 0, E,      0, 0, 3'b100, 8'h11, 0);
        add(0, 1, 8'h22, 0, E,      0, 0, 3'b100, 8'h22, 0);
        add(0, 1, 8'h33, 0, E,      0, 0, 3'b100, 8'h33, 0);
        add(0, 0, 8'h0E, 0, E,      0, 0, 3'b100, 8'h0E, 0);
        add(0, 0, 8'h00, 0, E,      1, 0, 3'b000, 8'h00, 0);
        // len=0 packet
        add(0, 1, 8'h01, 0, E, 0, 0, 3'b000, 8'h00, 0);
        add(0, 0, 8'h01, 0, E, 1, 1, 3'b010, 8'h01, 0);
        add(0, 0, 8'h01, 0, E, 0, 0, 3'b010, 8'h01, 0);
        add(0, 0, 8'h00, 0, E, 1, 0, 3'b000, 8'h00, 0);
        // addr 3 dropped, then a normal header
        add(0, 1, 8'h07, 0, E, 0, 0, 3'b000, 8'h00, 0);
        add(0, 1, 8'hAA, 0, E, 0, 0, 3'b000, 8'h00, 0);
        add(0, 0, 8'h55, 0, E, 0, 0, 3'b000, 8'h00, 0);
        add(0, 1, 8'h0D, 0, E, 0, 0, 3'b000, 8'h00, 0);
        add(0, 1, 8'h11, 0, E, 1, 1, 3'b010, 8'h0D, 0);
        add(0, 1, 8'h11, 0, E, 0, 0, 3'b010, 8'h11, 0);
        // reset mid-packet, then a clean packet
        add(1, 1, 8'h22, 0, E, 0, 0, 3'b000, 8'h00, 0);
        add(1, 1, 8'h22, 0, E, 0, 0, 3'b000, 8'h00, 0);
        add(0, 1, 8'h0D, 0, E, 0, 0, 3'b000, 8'h00, 0);
        add(0, 1, 8'h11, 0, E, 1, 1, 3'b010, 8'h0D, 0);
        add(0, 1, 8'h11, 0, E, 0, 0, 3'b010, 8'h11, 0);
        add(0, 1, 8'h22, 0, E, 0, 0, 3'b010, 8'h22, 0);
        add(0, 1, 8'h33, 0, E, 0, 0, 3'b010, 8'h33, 0);
        add(0, 0, 8'h0D, 0, E, 0, 0, 3'b010, 8'h0D, 0);
        add(0, 0, 8'h00, 0, E, 1, 0, 3'b000, 8'h00, 0);
        add(0, 0, 8'h00, 0, E, 0, 0, 3'b000, 8'h00, 0);

        @(posedge clk);
        #1;
        for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

        // FIFO2 unread for 29 cycles, read on the 30th: no pulse
        for (int j = 0; j < 32; j++)
            apply(mk(0, 0, 8'h00, 0, 3'b011, (j >= 29) ? 3'b100 : 3'b000,
                     0, 0, 3'b000, 8'h00, 0, 3'b000), 1000 + j);
        apply(mk(0, 0, 8'h00, 0, E, 0, 0, 0, 3'b000, 8'h00, 0, 3'b000), 1100);

        // header to non-empty FIFO2 waits; timeout pulses after 30 cycles and drops the packet
        for (int j = 0; j < 30; j++)
            apply(mk(0, (j == 0), (j == 0) ? 8'h0A : 8'h11, 0, 3'b011, 0,
                     (j != 0), 0, 3'b000, 8'h00, 0, (j == 29) ? 3'b100 : 3'b000), 2000 + j);
        apply(mk(0, 1, 8'h11, 0, 3'b011, 0, 1, 0, 3'b000, 8'h00, 0, 3'b000), 2030);
        apply(mk(0, 1, 8'h22, 0, E,      0, 0, 0, 3'b000, 8'h00, 0, 3'b000), 2031);
        apply(mk(0, 0, 8'h0A, 0, E,      0, 0, 0, 3'b000, 8'h00, 0, 3'b000), 2032);
        apply(mk(0, 1, 8'h0D, 0, E,      0, 0, 0, 3'b000, 8'h00, 0, 3'b000), 2033);
        apply(mk(0, 1, 8'h11, 0, E,      0, 1, 1, 3'b010, 8'h0D, 0, 3'b000), 2034);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
